// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix loader/driver pair.
// The bank bit sits directly above the word index in every framebuffer address.
package matrix_pkg;

  localparam int ADDR_W_DEFAULT  = 8;
  localparam int WORDS_PER_CHAIN = 2 ** ADDR_W_DEFAULT;
  localparam int BYTES_PER_FRAME = 4 * WORDS_PER_CHAIN;
  localparam int BANK_BIT        = ADDR_W_DEFAULT;

  typedef enum logic [1:0] {
    RX_LO     = 2'd0,
    RX_HI     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_e;

  // Two chains per frame, one 16-bit word per LED.
  function automatic int words_per_frame(input int addr_w);
    return 2 * (2 ** addr_w);
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Host byte stream into the frame loader: valid/ready bytes plus a start-of-frame pulse.
interface frame_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_start;

  modport master (output rx_data, output rx_valid, output rx_start, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input rx_start, output rx_ready);
endinterface

// File: rtl/bank_swap.sv
// Displayed-bank ownership: holds a finished frame pending and flips the bank on a
// qualified end-of-frame pulse, or after SWAP_TIMEOUT cycles when that is non-zero.
module bank_swap #(
  parameter int SWAP_TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set_pending,
  input  logic i_frame_done,
  output logic o_swap,
  output logic o_rd_bank,
  output logic o_frame_pending
);

  localparam int CNT_W = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;

  logic             rd_bank_q, rd_bank_d;
  logic             pending_q, pending_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  if (SWAP_TIMEOUT != 0) begin : g_timeout
    assign timeout = pending_q && (cnt_q == CNT_W'(SWAP_TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  // armed_q lags pending by a cycle so a done pulse coincident with the rise is ignored.
  always_comb begin
    o_swap    = pending_q && ((armed_q && i_frame_done) || timeout);
    rd_bank_d = rd_bank_q ^ o_swap;
    pending_d = (pending_q && !o_swap) || i_set_pending;
    armed_d   = pending_q && !o_swap;
    cnt_d     = (pending_q && !o_swap) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_bank_q <= 1'b0;
      pending_q <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rd_bank_q <= rd_bank_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_rd_bank       = rd_bank_q;
  assign o_frame_pending = pending_q;

endmodule

// File: rtl/frame_loader.sv
// Assembles host bytes into 16-bit pixel words and writes them into the hidden bank of
// two double-banked framebuffers; a write strobe follows the second byte by one cycle.
module frame_loader
  import matrix_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int SWAP_TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  frame_loader_if.slave     rx,
  input  logic              i_frame_done,
  output logic [ADDR_W:0]   o_waddr_1,
  output logic [15:0]       o_wdata_1,
  output logic              o_we_1,
  output logic [ADDR_W:0]   o_waddr_2,
  output logic [15:0]       o_wdata_2,
  output logic              o_we_2,
  output logic              o_rd_bank,
  output logic              o_frame_pending,
  output logic              o_abort
);

  localparam int              IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(words_per_frame(ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we1_q, we1_d;
  logic              we2_q, we2_d;
  logic              abort_q, abort_d;
  logic              hs, set_pending, swap, rd_bank;

  assign rx.rx_ready = !i_rst && (state_q != WAIT_SWAP);
  assign hs          = rx.rx_valid && rx.rx_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we1_d       = 1'b0;
    we2_d       = 1'b0;
    abort_d     = 1'b0;
    set_pending = 1'b0;
    case (state_q)
      RX_LO, RX_HI: begin
        // A restart mid-frame drops any half word; a byte in the same cycle opens the new frame.
        if (rx.rx_start && (state_q == RX_HI || idx_q != '0)) begin
          abort_d = 1'b1;
          idx_d   = '0;
          state_d = RX_LO;
          if (hs) begin
            lo_d    = rx.rx_data;
            state_d = RX_HI;
          end
        end else if (hs) begin
          if (state_q == RX_LO) begin
            lo_d    = rx.rx_data;
            state_d = RX_HI;
          end else begin
            waddr_d = {~rd_bank, idx_q[ADDR_W-1:0]};
            wdata_d = {rx.rx_data, lo_q};
            we1_d   = ~idx_q[ADDR_W];
            we2_d   = idx_q[ADDR_W];
            if (idx_q == LAST_IDX) begin
              state_d     = WAIT_SWAP;
              set_pending = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = RX_LO;
            end
          end
        end
      end
      WAIT_SWAP: begin
        if (swap) begin
          state_d = RX_LO;
          idx_d   = '0;
        end
      end
      default: state_d = RX_LO;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RX_LO;
      idx_q   <= '0;
      lo_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we1_q   <= we1_d;
      we2_q   <= we2_d;
      abort_q <= abort_d;
    end
  end

  bank_swap #(
    .SWAP_TIMEOUT(SWAP_TIMEOUT)
  ) u_bank_swap (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_set_pending  (set_pending),
    .i_frame_done   (i_frame_done),
    .o_swap         (swap),
    .o_rd_bank      (rd_bank),
    .o_frame_pending(o_frame_pending)
  );

  assign o_waddr_1 = waddr_q;
  assign o_wdata_1 = wdata_q;
  assign o_we_1    = we1_q;
  assign o_waddr_2 = waddr_q;
  assign o_wdata_2 = wdata_q;
  assign o_we_2    = we2_q;
  assign o_rd_bank = rd_bank;
  assign o_abort   = abort_q;

endmodule
